mem_bus_arbiter: RTL and testbench

//   Shares the single data-memory bus between the fetch stage (instruction reads) and the
//   mem-access stage (loads/stores). Sequences one bus transaction at a time:

---
 rtl/mem_bus_arbiter.sv | 162 ++++++++++++++++
 tb/tb_mem_bus_arbiter.sv | 232 +++++++++++++++++++++++
 2 files changed

// File: rtl/mem_bus_arbiter.sv
// Shares one data-memory bus between fetch and mem-access stages, one transaction at a time.
// Optional watchdog enabled by MEM_ARB_TIMEOUT_EN (sets sticky arb_err and aborts the access).
module mem_bus_arbiter #(
  parameter int ADDR_W      = 32,
  parameter int DATA_W      = 32,
  parameter int TIMEOUT_CYC = 255
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_req,
  input  logic [ADDR_W-1:0] i_addr,
  output logic [DATA_W-1:0] i_rdata,
  output logic              i_done,
  output logic              i_stall,
  input  logic [1:0]        d_req,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [1:0]        d_size,
  input  logic [DATA_W-1:0] d_wdata,
  output logic [DATA_W-1:0] d_rdata,
  output logic              d_done,
  output logic              d_stall,
  output logic [ADDR_W-1:0] daddr,
  output logic              dreq,
  output logic              dwrite,
  output logic [1:0]        dsize,
  output logic [DATA_W-1:0] input_ddata,
  input  logic [DATA_W-1:0] output_ddata,
  input  logic              dready_n,
  input  logic              dbusy,
  output logic              arb_err
);

  typedef enum logic [1:0] {IDLE, GRANT_D, GRANT_I} state_t;

  localparam logic [1:0] SIZE_WORD = 2'b10;

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [1:0]        size_q, size_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic              write_q, write_d;
  logic              i_done_q, i_done_d, d_done_q, d_done_d;
  logic [DATA_W-1:0] i_rdata_q, i_rdata_d, d_rdata_q, d_rdata_d;
  logic              timeout;

`ifdef MEM_ARB_TIMEOUT_EN
  localparam int CNT_W = ($clog2(TIMEOUT_CYC + 1) > 8) ? $clog2(TIMEOUT_CYC + 1) : 8;

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             err_q, err_d;

  // Counter sits at zero in IDLE, so it is cleared on every grant entry.
  always_comb begin
    cnt_d = cnt_q;
    if (state_q == IDLE) cnt_d = '0;
    else if (dready_n)   cnt_d = cnt_q + 1'b1;
  end

  assign timeout = (state_q != IDLE) && dready_n && (cnt_q == CNT_W'(TIMEOUT_CYC - 1));
  assign err_d   = err_q | timeout;
  assign arb_err = err_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
      err_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      err_q <= err_d;
    end
  end
`else
  localparam int unused_timeout_cyc = TIMEOUT_CYC;

  assign timeout = 1'b0;
  assign arb_err = 1'b0;
`endif

  always_comb begin
    state_d   = state_q;
    addr_d    = addr_q;
    size_d    = size_q;
    wdata_d   = wdata_q;
    write_d   = write_q;
    i_done_d  = 1'b0;
    d_done_d  = 1'b0;
    i_rdata_d = i_rdata_q;
    d_rdata_d = d_rdata_q;
    case (state_q)
      IDLE: begin
        // Requests are still asserted during a done cycle; ignore them so nothing is reissued.
        if (!dbusy && !i_done_q && !d_done_q) begin
          if (|d_req) begin
            addr_d  = d_addr;
            size_d  = d_size;
            wdata_d = d_wdata;
            write_d = d_req[0];
            state_d = GRANT_D;
          end else if (i_req) begin
            addr_d  = i_addr;
            size_d  = SIZE_WORD;
            wdata_d = '0;
            write_d = 1'b0;
            state_d = GRANT_I;
          end
        end
      end
      GRANT_D: begin
        if (!dready_n || timeout) begin
          d_done_d  = 1'b1;
          d_rdata_d = (write_q || timeout) ? '0 : output_ddata;
          state_d   = IDLE;
        end
      end
      GRANT_I: begin
        if (!dready_n || timeout) begin
          i_done_d  = 1'b1;
          i_rdata_d = timeout ? '0 : output_ddata;
          state_d   = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      addr_q    <= '0;
      size_q    <= '0;
      wdata_q   <= '0;
      write_q   <= 1'b0;
      i_done_q  <= 1'b0;
      d_done_q  <= 1'b0;
      i_rdata_q <= '0;
      d_rdata_q <= '0;
    end else begin
      state_q   <= state_d;
      addr_q    <= addr_d;
      size_q    <= size_d;
      wdata_q   <= wdata_d;
      write_q   <= write_d;
      i_done_q  <= i_done_d;
      d_done_q  <= d_done_d;
      i_rdata_q <= i_rdata_d;
      d_rdata_q <= d_rdata_d;
    end
  end

  assign dreq        = (state_q != IDLE);
  assign dwrite      = (state_q == GRANT_D) && write_q;
  assign daddr       = addr_q;
  assign dsize       = size_q;
  assign input_ddata = dwrite ? wdata_q : '0;
  assign i_done      = i_done_q;
  assign d_done      = d_done_q;
  assign i_rdata     = i_rdata_q;
  assign d_rdata     = d_rdata_q;
  assign i_stall     = i_req & ~i_done_q;
  assign d_stall     = (|d_req) & ~d_done_q;

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Directed bench for mem_bus_arbiter: bus-side responder driven per step, scoreboard of expected accesses.
module tb_mem_bus_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        i_req;
  logic [31:0] i_addr;
  logic [31:0] i_rdata;
  logic        i_done, i_stall;
  logic [1:0]  d_req;
  logic [31:0] d_addr;
  logic [1:0]  d_size;
  logic [31:0] d_wdata;
  logic [31:0] d_rdata;
  logic        d_done, d_stall;
  logic [31:0] daddr;
  logic        dreq, dwrite;
  logic [1:0]  dsize;
  logic [31:0] input_ddata;
  logic [31:0] output_ddata;
  logic        dready_n, dbusy;
  logic        arb_err;

  int vectors     = 0;
  int miscompares = 0;
  int cyc         = 0;
  int last_done   = 0;

  typedef struct {
    bit          is_d;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        wr;
    logic [1:0]  size;
    logic [31:0] rdata;
  } exp_t;

  exp_t sb[$];

  mem_bus_arbiter #(.ADDR_W(32), .DATA_W(32), .TIMEOUT_CYC(8)) dut (
    .clk(clk), .rst(rst),
    .i_req(i_req), .i_addr(i_addr), .i_rdata(i_rdata), .i_done(i_done), .i_stall(i_stall),
    .d_req(d_req), .d_addr(d_addr), .d_size(d_size), .d_wdata(d_wdata),
    .d_rdata(d_rdata), .d_done(d_done), .d_stall(d_stall),
    .daddr(daddr), .dreq(dreq), .dwrite(dwrite), .dsize(dsize),
    .input_ddata(input_ddata), .output_ddata(output_ddata),
    .dready_n(dready_n), .dbusy(dbusy), .arb_err(arb_err)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic push(input bit is_d, input logic [31:0] addr, input logic [31:0] wdata,
                      input logic wr, input logic [1:0] size, input logic [31:0] rdata);
    exp_t e;
    e.is_d = is_d; e.addr = addr; e.wdata = wdata; e.wr = wr; e.size = size; e.rdata = rdata;
    sb.push_back(e);
  endtask

  task automatic wait_grant();
    int n = 0;
    while (dreq !== 1'b1 && n < 50) begin
      @(negedge clk);
      n++;
    end
    chk("dreq_grant", dreq, 1);
  endtask

  // Completes the oldest expected access: checks bus fields, stalls, done pulse and data.
  task automatic serve(input int delay, input logic [31:0] bus_rd, input bit drop);
    exp_t e;
    if (sb.size() == 0) begin
      chk("sb_nonempty", 0, 1);
      return;
    end
    e = sb.pop_front();
    wait_grant();
    chk("daddr", daddr, e.addr);
    chk("dwrite", dwrite, e.wr);
    chk("input_ddata", input_ddata, e.wr ? e.wdata : 32'h0);
    chk("dsize", dsize, e.size);
    if (drop) begin
      i_req = 1'b0;
      d_req = 2'b00;
    end
    output_ddata = bus_rd;
    for (int k = 0; k < delay; k++) begin
      dready_n = 1'b1;
      @(negedge clk);
      chk("stall_wait", e.is_d ? d_stall : i_stall, drop ? 0 : 1);
      chk("no_early_done", e.is_d ? d_done : i_done, 0);
      chk("dreq_hold", dreq, 1);
    end
    dready_n = 1'b0;
    @(negedge clk);
    dready_n = 1'b1;
    chk("done_pulse", e.is_d ? d_done : i_done, 1);
    chk("other_done", e.is_d ? i_done : d_done, 0);
    chk("rdata", e.is_d ? d_rdata : i_rdata, e.rdata);
    chk("dreq_done_cycle", dreq, 0);
    chk("stall_release", e.is_d ? d_stall : i_stall, 0);
    last_done = cyc;
  endtask

  initial begin
    int t1;
    rst = 1'b1; i_req = 1'b0; i_addr = '0; d_req = 2'b00; d_addr = '0; d_size = 2'b00;
    d_wdata = '0; output_ddata = '0; dready_n = 1'b1; dbusy = 1'b0;
    @(negedge clk); @(negedge clk);
    chk("rst_dreq", dreq, 0);
    chk("rst_dwrite", dwrite, 0);
    chk("rst_i_done", i_done, 0);
    chk("rst_d_done", d_done, 0);
    chk("rst_arb_err", arb_err, 0);
    chk("rst_daddr", daddr, 0);
    chk("rst_wdata", input_ddata, 0);
    chk("rst_rdata", {i_rdata, d_rdata}, 0);
    rst = 1'b0;

    // Reset in the middle of a data grant
    @(negedge clk);
    d_req = 2'b10; d_addr = 32'h80; d_size = 2'b10;
    wait_grant();
    #2 rst = 1'b1;
    #1;
    chk("midrst_dreq", dreq, 0);
    chk("midrst_d_done", d_done, 0);
    d_req = 2'b00;
    @(negedge clk);
    chk("midrst_no_done", d_done, 0);
    rst = 1'b0;
    @(negedge clk);
    chk("midrst_idle", dreq, 0);
    chk("midrst_no_done2", d_done, 0);

    // Load with three wait cycles
    d_req = 2'b10; d_addr = 32'h100; d_size = 2'b10;
    push(1, 32'h100, 32'h0, 1'b0, 2'b10, 32'hDEADBEEF);
    serve(3, 32'hDEADBEEF, 0);
    d_req = 2'b00;

    // Simultaneous store and fetch: store goes first
    @(negedge clk);
    i_req = 1'b1; i_addr = 32'h200;
    d_req = 2'b01; d_addr = 32'h40; d_wdata = 32'h12345678; d_size = 2'b10;
    push(1, 32'h40, 32'h12345678, 1'b1, 2'b10, 32'h0);
    push(0, 32'h200, 32'h0, 1'b0, 2'b10, 32'hCAFEF00D);
    serve(1, 32'hAAAA5555, 0);
    d_req = 2'b00;
    chk("fetch_pending_stall", i_stall, 1);
    serve(0, 32'hCAFEF00D, 0);

    // Memory busy holds the fetch off
    i_addr = 32'h300;
    dbusy = 1'b1;
    push(0, 32'h300, 32'h0, 1'b0, 2'b10, 32'h11112222);
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      chk("busy_no_dreq", dreq, 0);
    end
    dbusy = 1'b0;
    @(negedge clk);
    chk("grant_after_busy", dreq, 1);
    serve(0, 32'h11112222, 0);

    // Back-to-back fetches
    i_addr = 32'h0;
    push(0, 32'h0, 32'h0, 1'b0, 2'b10, 32'hA0A0A0A0);
    serve(0, 32'hA0A0A0A0, 0);
    t1 = last_done;
    i_addr = 32'h4;
    push(0, 32'h4, 32'h0, 1'b0, 2'b10, 32'hB1B1B1B1);
    serve(0, 32'hB1B1B1B1, 0);
    chk("b2b_spacing", last_done - t1, 3);
    i_req = 1'b0;

    // d_req=11 is a write; requester drops mid-grant but the access completes
    @(negedge clk);
    d_req = 2'b11; d_addr = 32'h600; d_wdata = 32'h55AA55AA; d_size = 2'b00;
    push(1, 32'h600, 32'h55AA55AA, 1'b1, 2'b00, 32'h0);
    serve(2, 32'hFFFFFFFF, 1);

    // Memory never answers
    @(negedge clk);
    d_req = 2'b10; d_addr = 32'h500; d_size = 2'b10;
    wait_grant();
`ifdef MEM_ARB_TIMEOUT_EN
    output_ddata = 32'h77777777;
    for (int k = 0; k < 7; k++) begin
      @(negedge clk);
      chk("to_no_done", d_done, 0);
    end
    @(negedge clk);
    chk("to_done", d_done, 1);
    chk("to_rdata", d_rdata, 0);
    chk("to_err", arb_err, 1);
    chk("to_dreq", dreq, 0);
    d_req = 2'b00;
    repeat (3) @(negedge clk);
    chk("to_err_sticky", arb_err, 1);
`else
    repeat (20) @(negedge clk);
    chk("wait_dreq_held", dreq, 1);
    chk("wait_no_done", d_done, 0);
    chk("wait_no_err", arb_err, 0);
    push(1, 32'h500, 32'h0, 1'b0, 2'b10, 32'h600DF00D);
    serve(0, 32'h600DF00D, 0);
    d_req = 2'b00;
    @(negedge clk);
    chk("err_const0", arb_err, 0);
`endif
    chk("sb_drained", sb.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
